// File: rtl/mem_i_d_dp.sv
// Dual-port synchronous block RAM: port A is a read-only instruction fetch
// port, port B is a byte-enabled read/write data port. Both ports share one
// array, have a selectable read latency and flag out-of-range accesses.
module mem_i_d_dp #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DEPTH      = 8192,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned WRITE_MODE = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                A_En,
  input  logic [ADDR_W-1:0]   A_Addr,
  output logic [DATA_W-1:0]   A_Out,
  output logic                A_Valid,
  input  logic                B_En,
  input  logic [DATA_W/8-1:0] B_W_En,
  input  logic [ADDR_W-1:0]   B_Addr,
  input  logic [DATA_W-1:0]   B_In,
  output logic [DATA_W-1:0]   B_Out,
  output logic                B_Valid,
  output logic                Err
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam bit          FULL = (64'(DEPTH) == (64'd1 << ADDR_W));

  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_ok, b_ok, b_wr;
  logic [DATA_W-1:0] b_old, b_merged;
  logic              a_v1, b_v1, err_q;
  logic [DATA_W-1:0] a_d1, b_d1;

  // Address range qualification; trivially true when the array spans the address space
  if (FULL) begin : g_full
    assign a_ok = 1'b1;
    assign b_ok = 1'b1;
  end else begin : g_part
    assign a_ok = (A_Addr < ADDR_W'(DEPTH));
    assign b_ok = (B_Addr < ADDR_W'(DEPTH));
  end

  assign b_wr  = B_En & (|B_W_En);
  assign b_old = b_ok ? mem[B_Addr] : '0;

  // Merge the byte-enabled write data over the current word (write-first view)
  always_comb begin
    b_merged = b_old;
    for (int i = 0; i < NB; i++) begin
      if (B_W_En[i]) b_merged[8*i +: 8] = B_In[8*i +: 8];
    end
  end

  // Byte-enabled array write; out-of-range writes and writes during reset are dropped
  always_ff @(posedge clk) begin
    if (!rst && b_wr && b_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (B_W_En[i]) mem[B_Addr][8*i +: 8] <= B_In[8*i +: 8];
      end
    end
  end

  // First read stage: array read, read-during-write policy, sticky range error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v1  <= 1'b0;
      a_d1  <= '0;
      b_v1  <= 1'b0;
      b_d1  <= '0;
      err_q <= 1'b0;
    end else begin
      a_v1 <= A_En;
      if (A_En) a_d1 <= a_ok ? mem[A_Addr] : '0;
      b_v1 <= 1'b0;
      if (B_En) begin
        if (!b_wr) begin
          b_v1 <= 1'b1;
          b_d1 <= b_old;
        end else if (WRITE_MODE == 0) begin
          b_v1 <= 1'b1;
          b_d1 <= b_ok ? b_merged : '0;
        end else if (WRITE_MODE == 1) begin
          b_v1 <= 1'b1;
          b_d1 <= b_old;
        end
      end
      err_q <= err_q | (A_En & ~a_ok) | (B_En & ~b_ok);
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              a_v2, b_v2;
    logic [DATA_W-1:0] a_d2, b_d2;

    // Second output stage; data only advances with a valid so outputs hold otherwise
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_v2 <= 1'b0;
        a_d2 <= '0;
        b_v2 <= 1'b0;
        b_d2 <= '0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_d2 <= a_d1;
        if (b_v1) b_d2 <= b_d1;
      end
    end

    assign A_Out   = a_d2;
    assign A_Valid = a_v2;
    assign B_Out   = b_d2;
    assign B_Valid = b_v2;
  end else begin : g_noreg
    assign A_Out   = a_d1;
    assign A_Valid = a_v1;
    assign B_Out   = b_d1;
    assign B_Valid = b_v1;
  end

  assign Err = err_q;

endmodule

// File: tb/tb_mem_i_d_dp.sv
// Bench for mem_i_d_dp: four instances share one stimulus stream.
// u0: write-first, DEPTH 6000, latency 1 (scoreboarded on every valid)
// u1: read-first, u2: no-change, u3: latency 2 (spot-checked by hand)
module tb_mem_i_d_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [12:0] a_addr, b_addr;
  logic [3:0]  b_we;
  logic [31:0] b_in;

  logic [31:0] a_out [4];
  logic [31:0] b_out [4];
  logic        a_valid [4];
  logic        b_valid [4];
  logic        err [4];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] qa [$];
  logic [31:0] qb [$];

  typedef struct {
    logic        a_e;
    logic [12:0] aa;
    logic [31:0] ae;
    logic        b_e;
    logic [3:0]  we;
    logic [12:0] ba;
    logic [31:0] bi;
    logic [31:0] be;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  mem_i_d_dp #(.DEPTH(6000), .OUT_REG(0), .WRITE_MODE(0)) u0 (
    .clk(clk), .rst(rst), .A_En(a_en), .A_Addr(a_addr), .A_Out(a_out[0]), .A_Valid(a_valid[0]),
    .B_En(b_en), .B_W_En(b_we), .B_Addr(b_addr), .B_In(b_in), .B_Out(b_out[0]),
    .B_Valid(b_valid[0]), .Err(err[0]));
  mem_i_d_dp #(.OUT_REG(0), .WRITE_MODE(1)) u1 (
    .clk(clk), .rst(rst), .A_En(a_en), .A_Addr(a_addr), .A_Out(a_out[1]), .A_Valid(a_valid[1]),
    .B_En(b_en), .B_W_En(b_we), .B_Addr(b_addr), .B_In(b_in), .B_Out(b_out[1]),
    .B_Valid(b_valid[1]), .Err(err[1]));
  mem_i_d_dp #(.OUT_REG(0), .WRITE_MODE(2)) u2 (
    .clk(clk), .rst(rst), .A_En(a_en), .A_Addr(a_addr), .A_Out(a_out[2]), .A_Valid(a_valid[2]),
    .B_En(b_en), .B_W_En(b_we), .B_Addr(b_addr), .B_In(b_in), .B_Out(b_out[2]),
    .B_Valid(b_valid[2]), .Err(err[2]));
  mem_i_d_dp #(.OUT_REG(1), .WRITE_MODE(0)) u3 (
    .clk(clk), .rst(rst), .A_En(a_en), .A_Addr(a_addr), .A_Out(a_out[3]), .A_Valid(a_valid[3]),
    .B_En(b_en), .B_W_En(b_we), .B_Addr(b_addr), .B_In(b_in), .B_Out(b_out[3]),
    .B_Valid(b_valid[3]), .Err(err[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; returns 1 time unit after the sampling edge
  task automatic drive(input logic a_e, input logic [12:0] aa, input logic [31:0] ae,
                       input logic b_e, input logic [3:0] we, input logic [12:0] ba,
                       input logic [31:0] bi, input logic [31:0] be);
    a_en = a_e; a_addr = aa; b_en = b_e; b_we = we; b_addr = ba; b_in = bi;
    if (a_e && !rst) qa.push_back(ae);
    if (b_e && !rst) qb.push_back(be);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 13'd0, 32'd0, 1'b0, 4'h0, 13'd0, 32'd0, 32'd0);
  endtask

  // Scoreboard for u0: every valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (a_valid[0]) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: got valid with %h, expected no valid", a_out[0]);
      end else check("a_scoreboard", a_out[0], qa.pop_front());
    end
    if (b_valid[0]) begin
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: got valid with %h, expected no valid", b_out[0]);
      end else check("b_scoreboard", b_out[0], qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //             a_e  aa      ae            b_e  we    ba      bi            be
    tbl[0] = '{1'b0, 13'd0, 32'h0,        1'b1, 4'hF, 13'd0, 32'h00000013, 32'h00000013};
    tbl[1] = '{1'b1, 13'd0, 32'h00000013, 1'b1, 4'hF, 13'd5, 32'hAABBCCDD, 32'hAABBCCDD};
    tbl[2] = '{1'b0, 13'd0, 32'h0,        1'b1, 4'h2, 13'd5, 32'h00001100, 32'hAABB11DD};
    tbl[3] = '{1'b1, 13'd5, 32'hAABB11DD, 1'b1, 4'h0, 13'd5, 32'h0,        32'hAABB11DD};
    tbl[4] = '{1'b0, 13'd0, 32'h0,        1'b1, 4'hF, 13'd7, 32'h00000001, 32'h00000001};
    tbl[5] = '{1'b0, 13'd0, 32'h0,        1'b1, 4'hF, 13'd9, 32'h00000005, 32'h00000005};
    tbl[6] = '{1'b0, 13'd0, 32'h0,        1'b1, 4'hF, 13'd1, 32'h00000011, 32'h00000011};
    tbl[7] = '{1'b0, 13'd0, 32'h0,        1'b1, 4'hF, 13'd2, 32'h00000022, 32'h00000022};
    tbl[8] = '{1'b1, 13'd1, 32'h00000011, 1'b1, 4'hF, 13'd3, 32'h00000033, 32'h00000033};
    tbl[9] = '{1'b1, 13'd3, 32'h00000033, 1'b1, 4'h0, 13'd0, 32'h0,        32'h00000013};

    rst = 1'b1;
    a_en = 1'b0; a_addr = '0; b_en = 1'b0; b_we = '0; b_addr = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out", a_out[0], 32'h0);
    check("rst_b_out", b_out[0], 32'h0);
    check("rst_valids", {a_valid[0], b_valid[0], a_valid[3], b_valid[3]}, 32'h0);
    check("rst_err", err[0], 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      drive(tbl[i].a_e, tbl[i].aa, tbl[i].ae, tbl[i].b_e, tbl[i].we, tbl[i].ba, tbl[i].bi, tbl[i].be);

    // Read-during-write on addr 7 (old 0x1, new 0x2)
    drive(1'b0, 13'd0, 32'h0, 1'b1, 4'hF, 13'd7, 32'h2, 32'h2);
    check("rdw_rf_valid", b_valid[1], 32'h1);
    check("rdw_rf_data", b_out[1], 32'h1);
    check("rdw_nc_valid", b_valid[2], 32'h0);
    check("rdw_nc_hold", b_out[2], 32'h13);
    check("rdw_wf_data", b_out[0], 32'h2);

    // Cross-port collision on addr 9
    drive(1'b1, 13'd9, 32'h5, 1'b1, 4'hF, 13'd9, 32'h6, 32'h6);
    check("coll_old", a_out[1], 32'h5);
    drive(1'b1, 13'd9, 32'h6, 1'b0, 4'h0, 13'd0, 32'h0, 32'h0);
    check("coll_new", a_out[1], 32'h6);
    idle();
    check("hold_valid", b_valid[0], 32'h0);
    check("hold_data", b_out[0], 32'h6);
    idle();

    // Two-cycle latency on u3, back-to-back
    drive(1'b1, 13'd1, 32'h11, 1'b0, 4'h0, 13'd0, 32'h0, 32'h0);
    check("oreg_c1_valid", a_valid[3], 32'h0);
    drive(1'b1, 13'd2, 32'h22, 1'b0, 4'h0, 13'd0, 32'h0, 32'h0);
    check("oreg_c2", {a_valid[3], a_out[3][30:0]}, {1'b1, 31'h11});
    drive(1'b1, 13'd3, 32'h33, 1'b0, 4'h0, 13'd0, 32'h0, 32'h0);
    check("oreg_c3", {a_valid[3], a_out[3][30:0]}, {1'b1, 31'h22});
    idle();
    check("oreg_c4", {a_valid[3], a_out[3][30:0]}, {1'b1, 31'h33});
    idle();
    check("oreg_c5_valid", a_valid[3], 32'h0);
    check("oreg_c5_hold", a_out[3], 32'h33);

    // Reset asserted with a request still in flight on u3
    drive(1'b1, 13'd1, 32'h11, 1'b0, 4'h0, 13'd0, 32'h0, 32'h0);
    drive(1'b1, 13'd2, 32'h22, 1'b0, 4'h0, 13'd0, 32'h0, 32'h0);
    check("rstmid_first", {a_valid[3], a_out[3][30:0]}, {1'b1, 31'h11});
    a_addr = 13'd3;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check("rstmid_u3_out", a_out[3], 32'h0);
    check("rstmid_u3_valid", a_valid[3], 32'h0);
    check("rstmid_u0_out", {a_out[0] | b_out[0]}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rstmid_hold_valid", {a_valid[3], a_valid[0]}, 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle();
      check("rstmid_after_valid", {a_valid[3], b_valid[3]}, 32'h0);
    end

    // Out-of-range on u0 (DEPTH 6000)
    check("oor_err_clear", err[0], 32'h0);
    drive(1'b0, 13'd0, 32'h0, 1'b1, 4'hF, 13'd6000, 32'hDEADBEEF, 32'h0);
    check("oor_err_set", err[0], 32'h1);
    check("oor_err_full", err[1], 32'h0);
    drive(1'b0, 13'd0, 32'h0, 1'b1, 4'h0, 13'd6000, 32'h0, 32'h0);
    check("oor_b_read", {b_valid[0], b_out[0][30:0]}, {1'b1, 31'h0});
    drive(1'b1, 13'd6000, 32'h0, 1'b0, 4'h0, 13'd0, 32'h0, 32'h0);
    check("oor_a_read", {a_valid[0], a_out[0][30:0]}, {1'b1, 31'h0});
    drive(1'b1, 13'd5999, 32'h0, 1'b1, 4'hF, 13'd5999, 32'h77, 32'h77);
    idle();
    idle();
    check("oor_err_sticky", err[0], 32'h1);
    rst = 1'b1;
    #1;
    check("oor_err_rst", err[0], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    check("oor_err_stays_clear", err[0], 32'h0);

    check("qa_drained", qa.size(), 32'h0);
    check("qb_drained", qb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
